bitonic_stream_ctrl: RTL and testbench
======================================

# bitonic_stream_ctrl

Sequential streaming front/back end for the 8-input combinational bitonic sorter chain (S1→S2→S3). It collects eight 8-bit numbers from a valid/ready input stream and presents them as one 64-bit word to the S1 inputs. It captures the S3 result into an output buffer and drains it one number per handshake on a valid/ready output stream. Loading of the next block overlaps draining of the current one.

## Interface
- DATA_W, 8, width of one number; block size is fixed at 8 numbers
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream number valid
- in_data  in  DATA_W  upstream number
- in_ready  out  1  block can accept a number
- sort_in  out  8*DATA_W  to sorter S1; slot 0 (first accepted) at [63:56] (number_in1), slot 7 at [7:0] (number_in8)
- sort_out  in  8*DATA_W  from sorter S3; [63:56] = number_out1 … [7:0] = number_out8
- out_valid  out  1  output number valid
- out_data  out  DATA_W  output number
- out_last  out  1  high with the 8th number of a block
- out_ready  in  1  downstream accepts
- blk_cnt  out  16  number of fully drained blocks, wraps 0xFFFF→0

## Operation
- Input side: in_cnt (0..7) and in_full flag. in_ready = !in_full.
- Input handshake (in_valid && in_ready): in_data is written to slot in_cnt of the input register (drives sort_in), and in_cnt increments. On slot 7: in_cnt→0, in_full←1.
- in_data is sampled only on a handshake; in_valid without in_ready has no effect.
- Output side: out_busy flag, out_cnt (0..7), and an 8×DATA_W output buffer. out_valid = out_busy. out_data = buffer[out_cnt], where buffer[0] = number_out1. out_last = out_busy && out_cnt==7.
- Output handshake (out_valid && out_ready): out_cnt increments. On out_cnt==7: out_cnt→0, out_busy←0, blk_cnt+1.
- Capture condition: in_full && (!out_busy || (out_valid && out_ready && out_last)).
- On capture: buffer←sort_out, out_busy←1, out_cnt←0, in_full←0.
- The capture bypass lets the last output handshake and the capture share one edge with no bubble. When capture and a final drain coincide, out_busy stays 1 and blk_cnt increments.
- sort_in is held stable while in_full, so the sorter result is settled at the capture edge.
- out_data/out_last stay stable while out_valid && !out_ready.
- Reset (any time, including mid-block): in_cnt, out_cnt, in_full, out_busy, blk_cnt, input register and buffer all clear. A partial input block or an undrained output block is discarded.
- Reset values of outputs: in_ready=1, sort_in=0, out_valid=0, out_data=0, out_last=0, blk_cnt=0.

## Timing
- Single clock; all state updates on the rising edge of clk; rst acts immediately.
- Latency: 8th input handshake at edge k → in_full high in cycle k+1 → capture at edge k+1 → out_valid=1 from cycle k+1 after that edge, with out_data = number_out1.
- in_ready is low for exactly the cycle(s) in_full is high; minimum 1 cycle per block.
- Sustained throughput with in_valid and out_ready held high: one block per 9 cycles on input. Output drains 8 of every 9 cycles, with one bubble from the capture latency. No input stall occurs if draining keeps up.
- Backpressure: if out_ready stays low, in_full holds, in_ready stays 0, and nothing is lost or overwritten.

## Test plan
- Reset/idle: assert rst for 3 cycles, release → in_ready=1, out_valid=0, sort_in=0, blk_cnt=0.
- Single block with a stub sorter (sort_out = byte-reversed sort_in): inputs 1,2,…,8 → sort_in=0x0102030405060708; output stream 8,7,…,1; out_last only on value 1; blk_cnt=1; out_valid first high 1 cycle after the 8th accept edge.
- Real S1–S3 chain: inputs 200,3,77,3,0,255,19,128 → output stream equals the S3 golden line for that pattern, in number_out1…8 order. Repeat over the full 4096-line pattern file with no mismatches.
- Back-to-back blocks, out_ready=1, in_valid=1: 3 blocks → 24 outputs in correct order; in_ready low exactly 1 cycle per block; blk_cnt=3.
- Backpressure: out_ready=0 during block 1 drain while block 2 is loaded → in_ready stays 0 after 8 accepts and block 2 data is unchanged. Releasing out_ready drains block 1, then block 2 is captured on the same edge as block 1's out_last handshake.
- Reset mid-operation: rst after 5 inputs and mid-drain (out_cnt=3) → all outputs return to reset values; the next 8 inputs form a clean new block.

Source files
------------

// File: rtl/bitonic_stream_ctrl.sv
// Streaming wrapper around the 8-input bitonic sorter: gathers 8 numbers into sort_in,
// captures the sorted word from sort_out and drains it one number per output handshake.
module bitonic_stream_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_W-1:0]     in_data_i,
  output logic                  in_ready_o,
  output logic [8*DATA_W-1:0]   sort_in_o,
  input  logic [8*DATA_W-1:0]   sort_out_i,
  output logic                  out_valid_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic [15:0]           blk_cnt_o
);
  localparam int NUM_LANES = 8;
  localparam logic [2:0] LAST = 3'(NUM_LANES - 1);

  logic [NUM_LANES-1:0][DATA_W-1:0] in_reg_q, in_reg_d, buf_q, buf_d, sort_lane;
  logic [2:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic        in_full_q, in_full_d, out_busy_q, out_busy_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        in_hs, out_hs, cap;

  // Lane 0 is the first number of a block and sits in the top byte of the sorter word.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sort_in_o[(NUM_LANES-1-g)*DATA_W +: DATA_W] = in_reg_q[g];
    assign sort_lane[g] = sort_out_i[(NUM_LANES-1-g)*DATA_W +: DATA_W];
  end

  assign in_ready_o  = !in_full_q;
  assign out_valid_o = out_busy_q;
  assign out_data_o  = buf_q[out_cnt_q];
  assign out_last_o  = out_busy_q && (out_cnt_q == LAST);
  assign blk_cnt_o   = blk_cnt_q;

  assign in_hs  = in_valid_i && !in_full_q;
  assign out_hs = out_busy_q && out_ready_i;
  // Capture may coincide with the final drain handshake so the output never bubbles twice.
  assign cap    = in_full_q && (!out_busy_q || (out_hs && out_cnt_q == LAST));

  always_comb begin
    in_reg_d   = in_reg_q;
    in_cnt_d   = in_cnt_q;
    in_full_d  = in_full_q;
    buf_d      = buf_q;
    out_cnt_d  = out_cnt_q;
    out_busy_d = out_busy_q;
    blk_cnt_d  = blk_cnt_q;
    if (in_hs) begin
      in_reg_d[in_cnt_q] = in_data_i;
      in_cnt_d = in_cnt_q + 3'd1;
      if (in_cnt_q == LAST) in_full_d = 1'b1;
    end
    if (out_hs) begin
      out_cnt_d = out_cnt_q + 3'd1;
      if (out_cnt_q == LAST) begin
        out_busy_d = 1'b0;
        blk_cnt_d  = blk_cnt_q + 16'd1;
      end
    end
    if (cap) begin
      buf_d      = sort_lane;
      out_busy_d = 1'b1;
      out_cnt_d  = 3'd0;
      in_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_reg_q   <= '0;
      in_cnt_q   <= '0;
      in_full_q  <= 1'b0;
      buf_q      <= '0;
      out_cnt_q  <= '0;
      out_busy_q <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      in_reg_q   <= in_reg_d;
      in_cnt_q   <= in_cnt_d;
      in_full_q  <= in_full_d;
      buf_q      <= buf_d;
      out_cnt_q  <= out_cnt_d;
      out_busy_q <= out_busy_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end
endmodule

// File: tb/tb_bitonic_stream_ctrl.sv
// Bench for bitonic_stream_ctrl: a behavioural sorter stub feeds sort_out, and a
// queue-based model of accepted blocks predicts the drained output stream.
module tb_bitonic_stream_ctrl;
  logic        clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_data;
  logic [63:0] sort_in, sort_out;
  logic [15:0] blk_cnt;
  bit          mode = 0;
  int          checks = 0, errors = 0, exp_blk = 0;
  logic [7:0]  inq[$];
  logic [8:0]  expq[$], outq[$];
  logic [63:0] mon_w, mon_r;

  always #5 clk = ~clk;

  // mode 0: byte reversal stub; mode 1: full descending sort (number_out1 = largest)
  function automatic logic [63:0] sorter_model(input logic [63:0] v, input bit m);
    logic [7:0] a[8];
    logic [7:0] t;
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) a[i] = v[63-8*i -: 8];
    if (m) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 7 - i; j++)
          if (a[j] < a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      for (int i = 0; i < 8; i++) r[63-8*i -: 8] = a[i];
    end else begin
      for (int i = 0; i < 8; i++) r[63-8*i -: 8] = a[7-i];
    end
    return r;
  endfunction

  assign sort_out = sorter_model(sort_in, mode);

  bitonic_stream_ctrl #(.DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .sort_in_o(sort_in), .sort_out_i(sort_out), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_last_o(out_last), .out_ready_i(out_ready), .blk_cnt_o(blk_cnt)
  );

  // Records accepted numbers (building expected blocks) and observed output handshakes.
  always @(negedge clk) begin
    if (rst) begin
      inq.delete(); expq.delete(); outq.delete();
    end else begin
      if (in_valid && in_ready) begin
        inq.push_back(in_data);
        if (inq.size() == 8) begin
          mon_w = {inq[0], inq[1], inq[2], inq[3], inq[4], inq[5], inq[6], inq[7]};
          mon_r = sorter_model(mon_w, mode);
          for (int i = 0; i < 8; i++) expq.push_back({(i == 7) ? 1'b1 : 1'b0, mon_r[63-8*i -: 8]});
          inq.delete();
        end
      end
      if (out_valid && out_ready) outq.push_back({out_last, out_data});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0; exp_blk = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sort_in !== 64'h0) begin errors++; $display("FAIL reset_sort_in got %h want 0", sort_in); end
    checks++; if (blk_cnt !== 16'h0) begin errors++; $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); end
    checks++; if (out_data !== 8'h0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_out_data got %h/%b want 0/0", out_data, out_last); end
  endtask

  task automatic test_single_block();
    int ob;
    ob = outq.size(); mode = 0; out_ready = 0;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = 8'(i + 1); tick(); end
    in_valid = 0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_full_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    checks++; if (sort_in !== 64'h0102030405060708) begin errors++; $display("FAIL single_sort_in got %h want 0102030405060708", sort_in); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'd8 || out_last !== 1'b0) begin errors++; $display("FAIL single_first_out got v%b d%0d l%b want v1 d8 l0", out_valid, out_data, out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after_cap got %b want 1", in_ready); end
    out_ready = 1;
    repeat (8) tick();
    out_ready = 0;
    checks++; if (outq.size() - ob != 8) begin errors++; $display("FAIL single_count got %0d want 8", outq.size() - ob); end
    for (int i = 0; i < 8; i++)
      if (ob + i < outq.size()) begin
        checks++;
        if (outq[ob+i] !== {(i == 7) ? 1'b1 : 1'b0, 8'(8 - i)}) begin errors++; $display("FAIL single_out[%0d] got %h want %h", i, outq[ob+i], {(i == 7) ? 1'b1 : 1'b0, 8'(8 - i)}); end
      end
    exp_blk++;
    checks++; if (blk_cnt !== 16'(exp_blk) || out_valid !== 1'b0) begin errors++; $display("FAIL single_blk_cnt got %0d v%b want %0d v0", blk_cnt, out_valid, exp_blk); end
  endtask

  task automatic test_sorted_block();
    logic [7:0] pat[8], gold[8];
    int ob, c;
    pat  = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd0, 8'd255, 8'd19, 8'd128};
    gold = '{8'd255, 8'd200, 8'd128, 8'd77, 8'd19, 8'd3, 8'd3, 8'd0};
    ob = outq.size(); mode = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = pat[i]; tick(); end
    in_valid = 0; c = 0;
    while (outq.size() - ob < 8 && c < 30) begin tick(); c++; end
    out_ready = 0;
    checks++; if (outq.size() - ob != 8) begin errors++; $display("FAIL sorted_timeout got %0d outputs want 8", outq.size() - ob); end
    for (int i = 0; i < 8; i++)
      if (ob + i < outq.size()) begin
        checks++;
        if (outq[ob+i] !== {(i == 7) ? 1'b1 : 1'b0, gold[i]}) begin errors++; $display("FAIL sorted_out[%0d] got %h want %h", i, outq[ob+i], {(i == 7) ? 1'b1 : 1'b0, gold[i]}); end
      end
    exp_blk++;
  endtask

  task automatic test_back_to_back();
    int ob, eb, n, low;
    ob = outq.size(); eb = expq.size(); mode = 1; out_ready = 1; n = 0; low = 0;
    for (int c = 0; c < 40; c++) begin
      if (n < 24) begin in_valid = 1; in_data = 8'($urandom); end else in_valid = 0;
      if (!in_ready) low++; else if (in_valid) n++;
      tick();
    end
    in_valid = 0; out_ready = 0;
    checks++; if (low != 3) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 3", low); end
    checks++; if (outq.size() - ob != 24) begin errors++; $display("FAIL b2b_count got %0d want 24", outq.size() - ob); end
    for (int i = 0; i < 24; i++)
      if (ob + i < outq.size() && eb + i < expq.size()) begin
        checks++;
        if (outq[ob+i] !== expq[eb+i]) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", i, outq[ob+i], expq[eb+i]); end
      end
    exp_blk += 3;
    checks++; if (blk_cnt !== 16'(exp_blk)) begin errors++; $display("FAIL b2b_blk_cnt got %0d want %0d", blk_cnt, exp_blk); end
  endtask

  task automatic test_backpressure();
    int ob, eb;
    logic [63:0] bw;
    ob = outq.size(); eb = expq.size(); mode = 0; out_ready = 0;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = 8'($urandom); tick(); end
    in_valid = 0; tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_blockA_valid got %b want 1", out_valid); end
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = 8'($urandom); bw[63-8*i -: 8] = in_data; tick(); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_data = 8'($urandom);
      checks++;
      if (in_ready !== 1'b0 || sort_in !== bw || out_valid !== 1'b1 || out_data !== expq[eb][7:0])
        begin errors++; $display("FAIL bp_hold c%0d got r%b s%h d%h want r0 s%h d%h", c, in_ready, sort_in, out_data, bw, expq[eb][7:0]); end
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (8) tick();
    checks++;
    if (expq.size() < eb + 16) begin errors++; $display("FAIL bp_model got %0d expected entries want %0d", expq.size() - eb, 16); end
    else if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== expq[eb+8][7:0])
      begin errors++; $display("FAIL bp_bypass got v%b r%b d%h want v1 r1 d%h", out_valid, in_ready, out_data, expq[eb+8][7:0]); end
    repeat (8) tick();
    out_ready = 0;
    checks++; if (outq.size() - ob != 16) begin errors++; $display("FAIL bp_count got %0d want 16", outq.size() - ob); end
    for (int i = 0; i < 16; i++)
      if (ob + i < outq.size() && eb + i < expq.size()) begin
        checks++;
        if (outq[ob+i] !== expq[eb+i]) begin errors++; $display("FAIL bp_out[%0d] got %h want %h", i, outq[ob+i], expq[eb+i]); end
      end
    exp_blk += 2;
    checks++; if (blk_cnt !== 16'(exp_blk)) begin errors++; $display("FAIL bp_blk_cnt got %0d want %0d", blk_cnt, exp_blk); end
  endtask

  task automatic test_reset_mid();
    int c;
    mode = 0; out_ready = 0;
    for (int i = 0; i < 5; i++) begin in_valid = 1; in_data = 8'($urandom); tick(); end
    in_valid = 0; rst = 1; #1;
    checks++; if (in_ready !== 1'b1 || sort_in !== 64'h0 || out_valid !== 1'b0 || blk_cnt !== 16'h0)
      begin errors++; $display("FAIL rst_partial got r%b s%h v%b b%0d want r1 s0 v0 b0", in_ready, sort_in, out_valid, blk_cnt); end
    @(negedge clk); tick(); rst = 0; exp_blk = 0;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = 8'($urandom); tick(); end
    in_valid = 0; tick();
    out_ready = 1; repeat (3) tick(); out_ready = 0;
    checks++;
    if (expq.size() < 8) begin errors++; $display("FAIL rst_mid_model got %0d entries want 8", expq.size()); end
    else if (out_data !== expq[3][7:0]) begin errors++; $display("FAIL rst_mid_pos got %h want %h", out_data, expq[3][7:0]); end
    rst = 1; #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h0 || out_last !== 1'b0 || in_ready !== 1'b1 || sort_in !== 64'h0)
      begin errors++; $display("FAIL rst_drain got v%b d%h l%b r%b s%h want v0 d0 l0 r1 s0", out_valid, out_data, out_last, in_ready, sort_in); end
    @(negedge clk); tick(); rst = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = 8'($urandom); tick(); end
    in_valid = 0; c = 0;
    while (outq.size() < 8 && c < 30) begin tick(); c++; end
    out_ready = 0;
    checks++; if (outq.size() != 8) begin errors++; $display("FAIL rst_clean_count got %0d want 8", outq.size()); end
    for (int i = 0; i < 8; i++)
      if (i < outq.size() && i < expq.size()) begin
        checks++;
        if (outq[i] !== expq[i]) begin errors++; $display("FAIL rst_clean_out[%0d] got %h want %h", i, outq[i], expq[i]); end
      end
    exp_blk = 1;
    checks++; if (blk_cnt !== 16'(exp_blk)) begin errors++; $display("FAIL rst_clean_blk got %0d want %0d", blk_cnt, exp_blk); end
  endtask

  task automatic test_random();
    int ob, eb, sent, c;
    ob = outq.size(); eb = expq.size(); mode = 1; sent = 0; c = 0;
    while (outq.size() - ob < 128 && c < 3000) begin
      in_valid  = (sent < 128) && ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) sent++;
      tick(); c++;
    end
    in_valid = 0; out_ready = 0;
    checks++; if (outq.size() - ob != 128) begin errors++; $display("FAIL rand_timeout got %0d outputs want 128", outq.size() - ob); end
    for (int i = 0; i < 128; i++)
      if (ob + i < outq.size() && eb + i < expq.size()) begin
        checks++;
        if (outq[ob+i] !== expq[eb+i]) begin errors++; $display("FAIL rand_out[%0d] got %h want %h", i, outq[ob+i], expq[eb+i]); end
      end
    exp_blk += 16;
    checks++; if (blk_cnt !== 16'(exp_blk)) begin errors++; $display("FAIL rand_blk_cnt got %0d want %0d", blk_cnt, exp_blk); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_sorted_block();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
